// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order fetches under a credit limit,
// buffers returned instructions with their PCs and squashes stale fetches on redirect.
module ifetch_stage #(
    parameter int              PC_W     = 64,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [PC_W-1:0]   if_pc,
    input  logic              if_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [CNT_W-1:0]   outstanding_reg, outstanding_next;
    logic [CNT_W-1:0]   drop_reg, drop_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    // PCs of in-flight requests, popped in order as responses return
    logic [PC_W-1:0]    pcq_mem [DEPTH];
    logic [PTR_W-1:0]   pcq_wr_reg, pcq_rd_reg;

    logic [PC_W-1:0]    buf_pc_mem   [DEPTH];
    logic [INST_W-1:0]  buf_inst_mem [DEPTH];
    logic [PTR_W-1:0]   buf_wr_reg, buf_rd_reg;

    logic req_fire;
    logic rsp_fire;
    logic rsp_keep;
    logic pop;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid;
    // A response arriving alongside a redirect belongs to the old path
    assign rsp_keep = rsp_fire && (drop_reg == '0) && !redirect_valid;
    assign pop      = if_valid && if_ready && !redirect_valid;

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        drop_next        = drop_reg;
        count_next       = count_reg + CNT_W'(rsp_keep) - CNT_W'(pop);
        if (redirect_valid) begin
            pc_next    = redirect_pc;
            drop_next  = outstanding_next;
            count_next = '0;
        end else begin
            if (req_fire) begin
                pc_next = pc_reg + PC_W'(4);
            end
            if (rsp_fire && (drop_reg != '0)) begin
                drop_next = drop_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH: if (redirect_valid && (drop_next != '0)) state_next = FLUSH;
            FLUSH: if (drop_next == '0) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Credit check looks only at registered occupancy so it never depends on if_ready
    always_comb begin
        imem_req_valid = 1'b0;
        if ((state_reg == FETCH) && !srst &&
            (({1'b0, outstanding_reg} + {1'b0, count_reg}) < CREDITS)) begin
            imem_req_valid = 1'b1;
        end
    end

    assign imem_req_addr = pc_reg;
    assign if_valid      = (count_reg != '0);
    assign if_inst       = buf_inst_mem[buf_rd_reg];
    assign if_pc         = buf_pc_mem[buf_rd_reg];

    always_ff @(posedge clk) begin
        if (srst) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            count_reg       <= '0;
            pcq_wr_reg      <= '0;
            pcq_rd_reg      <= '0;
            buf_wr_reg      <= '0;
            buf_rd_reg      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_mem[i]   <= '0;
                buf_inst_mem[i] <= '0;
            end
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            count_reg       <= count_next;
            if (req_fire) begin
                pcq_mem[pcq_wr_reg] <= pc_reg;
            end
            pcq_wr_reg <= pcq_wr_reg + PTR_W'(req_fire);
            pcq_rd_reg <= pcq_rd_reg + PTR_W'(rsp_fire);
            if (rsp_keep) begin
                buf_pc_mem[buf_wr_reg]   <= pcq_mem[pcq_rd_reg];
                buf_inst_mem[buf_wr_reg] <= imem_rsp_data;
            end
            buf_wr_reg <= buf_wr_reg + PTR_W'(rsp_keep);
            buf_rd_reg <= redirect_valid ? buf_wr_reg : (buf_rd_reg + PTR_W'(pop));
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Randomized bench for ifetch_stage: an in-order memory with configurable latency drives
// the DUT while queues of in-flight and deliverable PCs predict every request and delivery.
`timescale 1ns/1ps
module tb_ifetch_stage;
    localparam int          PC_W     = 64;
    localparam int          INST_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        srst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic        if_ready;

    always #5 clk = ~clk;

    ifetch_stage #(
        .PC_W(PC_W), .INST_W(INST_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .srst(srst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready)
    );

    typedef struct { logic [63:0] addr; int due; } mreq_t;
    typedef struct { logic [63:0] pc; bit stale; } flight_t;

    mreq_t       mem_q[$];
    flight_t     flight_q[$];
    logic [63:0] deliv_q[$];
    logic [63:0] model_pc;
    int          edge_no;
    int          last_due;
    int          tests;
    int          fails;
    bit          redir_fired;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0] ^ a[63:32];
        return {lo[15:0], lo[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    function automatic bit any_stale();
        foreach (flight_q[i]) if (flight_q[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, check DUT against the model, then advance the model
    // mode 0: no redirect, 1: redirect, 2: redirect only when a handshake and response coincide
    task automatic step(input bit rst, input bit rdy, input bit ifr, input int mode,
                        input logic [63:0] rpc, input int lat);
        bit          hs, rsp, redir, exp_rv;
        logic [63:0] addr;
        mreq_t       m;
        flight_t     f;
        int          due;
        srst = rst; imem_req_ready = rdy; if_ready = ifr;
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        exp_rv = !rst && !any_stale() && ((flight_q.size() + deliv_q.size()) < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        if (exp_rv && imem_req_valid) check("req_addr", imem_req_addr, model_pc);
        check("if_valid", if_valid, deliv_q.size() != 0);
        if (deliv_q.size() != 0 && if_valid) begin
            check("if_pc", if_pc, deliv_q[0]);
            check("if_inst", if_inst, inst_of(deliv_q[0]));
        end
        hs    = !rst && imem_req_valid && rdy;
        addr  = imem_req_addr;
        rsp   = !rst && (mem_q.size() != 0) && (mem_q[0].due <= edge_no + 1);
        redir = !rst && ((mode == 1) || (mode == 2 && hs && rsp));
        if (redir && mode == 2) redir_fired = 1'b1;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? inst_of(mem_q[0].addr) : $urandom();
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(posedge clk);
        edge_no++;
        if (rst) begin
            mem_q.delete(); flight_q.delete(); deliv_q.delete();
            model_pc = RESET_PC; last_due = 0;
        end else begin
            if (ifr && deliv_q.size() != 0 && !redir) begin
                $display("[TB] deliver pc=%h inst=%h", deliv_q[0], inst_of(deliv_q[0]));
                void'(deliv_q.pop_front());
            end
            if (hs) begin
                due = edge_no + 1 + lat;
                if (due <= last_due) due = last_due + 1;
                m.addr = addr; m.due = due;
                mem_q.push_back(m);
                last_due = due;
                f.pc = model_pc; f.stale = 1'b0;
                flight_q.push_back(f);
                if (!redir) model_pc = model_pc + 64'd4;
            end
            if (redir) begin
                foreach (flight_q[i]) flight_q[i].stale = 1'b1;
                model_pc = rpc;
            end
            if (rsp) begin
                void'(mem_q.pop_front());
                if (flight_q.size() != 0) begin
                    f = flight_q.pop_front();
                    if (!f.stale) deliv_q.push_back(f.pc);
                end
            end
            if (redir) deliv_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0; edge_no = 0; last_due = 0; redir_fired = 1'b0;
        model_pc = RESET_PC;
        srst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset, then streaming with 1-cycle memory
        repeat (2) step(1, 1, 1, 0, 0, 1);
        check("rst_if_inst", if_inst, 64'h0);
        check("rst_if_pc", if_pc, 64'h0);
        repeat (14) step(0, 1, 1, 0, 0, 1);

        // downstream stall fills the credits, then drains
        repeat (10) step(0, 1, 0, 0, 0, 1);
        repeat (12) step(0, 1, 1, 0, 0, 1);

        // slow memory with fetches in flight, redirect to 0x100
        step(1, 1, 1, 0, 0, 3);
        repeat (6) step(0, 1, 1, 0, 0, 3);
        step(0, 1, 1, 1, 64'h100, 3);
        repeat (15) step(0, 1, 1, 0, 0, 3);

        // redirect coinciding with both a response and a request handshake
        step(1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 30 && !redir_fired; i++) step(0, 1, 1, 2, 64'h200, 1);
        check("coincident_redirect_seen", redir_fired, 1'b1);
        repeat (10) step(0, 1, 1, 0, 0, 1);

        // reset in the middle of activity
        repeat (3) step(0, 1, 0, 0, 0, 2);
        repeat (2) step(1, 1, 0, 0, 0, 2);
        repeat (8) step(0, 1, 1, 0, 0, 1);

        // PC wrap-around
        step(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF4, 1);
        repeat (10) step(0, 1, 1, 0, 0, 1);

        // random readiness, latency and redirects
        for (int i = 0; i < 600; i++) begin
            step(0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                 (($urandom % 30) == 0) ? 1 : 0,
                 {$urandom(), $urandom()} & ~64'h3, $urandom_range(1, 3));
        end
        repeat (8) step(0, 1, 1, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
